rv32_muldiv_ctrl: RTL and testbench

RV32_MULDIV_CTRL -- requirements
Module: rv32_muldiv_ctrl

---
 rtl/rv32_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_rv32_muldiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_muldiv_ctrl
//
// Iterative RV32M multiply/divide unit that sits beside the EX stage.
//   - MUL/MULH/MULHSU/MULHU: 32-step shift-add on operand magnitudes into a
//     64-bit product, sign-corrected when the last step completes.
//   - DIV/DIVU/REM/REMU: 32-step restoring division on magnitudes, with the
//     RISC-V divide-by-zero and signed-overflow results.
//   - With EARLY_OUT=1 the divide-by-zero and overflow cases skip iteration
//     and finish in the cycle after the accept.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_alu_op        : alu_op_t code, 38..45 = MUL..REMU
//   req_rs1, req_rs2  : operands (rs1 = multiplicand / dividend)
//   req_rd, req_pc    : carried unchanged to the response
//   flush             : abort any in-flight or pending result
//   busy              : combinational stall request to EX
//   rsp_valid/ready   : response handshake, outputs held stable in DONE
//   rsp_data, rsp_rd, rsp_pc, rsp_wb_en : registered response fields
// ---------------------------------------------------------------------------
module rv32_muldiv_ctrl #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alu_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        busy,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_pc,
    output logic        rsp_wb_en
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Op index = alu_op - 38: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
    // 4 DIV, 5 DIVU, 6 REM, 7 REMU. Bit 2 set means divide family.
    function automatic logic op_signed_a(input logic [2:0] idx);
        return (idx == 3'd0) || (idx == 3'd1) || (idx == 3'd2) ||
               (idx == 3'd4) || (idx == 3'd6);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] idx);
        return (idx == 3'd0) || (idx == 3'd1) || (idx == 3'd4) || (idx == 3'd6);
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    // Multiply: m = multiplicand magnitude. Divide: m = divisor magnitude.
    logic [31:0] m_q, m_d;
    // Multiply: hi = partial product high half, lo = multiplier shifting out.
    // Divide:   hi = partial remainder,         lo = dividend in / quotient out.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        rsp_wb_en_q, rsp_wb_en_d;

    // Request decode. 38 mod 8 = 6, so (op - 38) mod 8 = op[2:0] + 2.
    logic        req_op_ok;
    logic [2:0]  req_idx;
    logic        req_neg_a, req_neg_b;
    logic [31:0] req_mag_a, req_mag_b;
    logic        req_div_zero, req_div_ovf, req_early;
    logic [31:0] req_early_data;

    always_comb begin
        req_op_ok      = (req_alu_op >= 6'd38) && (req_alu_op <= 6'd45);
        req_idx        = req_alu_op[2:0] + 3'd2;
        req_neg_a      = op_signed_a(req_idx) && req_rs1[31];
        req_neg_b      = op_signed_b(req_idx) && req_rs2[31];
        req_mag_a      = req_neg_a ? (~req_rs1 + 32'd1) : req_rs1;
        req_mag_b      = req_neg_b ? (~req_rs2 + 32'd1) : req_rs2;
        req_div_zero   = (req_rs2 == 32'd0);
        req_div_ovf    = ((req_idx == 3'd4) || (req_idx == 3'd6)) &&
                         (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
        req_early      = EARLY_OUT && req_idx[2] && (req_div_zero || req_div_ovf);
        // REM/REMU (idx[1] set within the divide family) return the remainder.
        if (req_idx[1])
            req_early_data = req_div_zero ? req_rs1 : 32'd0;
        else
            req_early_data = req_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    // One radix-2 step of the current operation.
    logic [32:0] mul_sum;
    logic [32:0] div_rsh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
        div_rsh  = {hi_q, lo_q[31]};
        div_ge   = (div_rsh >= {1'b0, m_q});
        // When div_ge holds the true difference is below m, so 32 bits suffice.
        div_diff = div_rsh[31:0] - m_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_rsh[31:0];
            step_lo = {lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo_q[31:1]};
        end
    end

    // Sign correction applied to the result of the final step.
    logic [63:0] prod_raw, prod_fix;
    logic [31:0] quot_fix, rem_fix, final_data;

    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw + 64'd1) : prod_raw;
        // Divisor zero iterates to an all-ones quotient; force it so the
        // signed sign fix-up cannot disturb the architectural value.
        if (m_q == 32'd0)
            quot_fix = 32'hFFFF_FFFF;
        else
            quot_fix = (neg_a_q ^ neg_b_q) ? (~step_lo + 32'd1) : step_lo;
        rem_fix  = neg_a_q ? (~step_hi + 32'd1) : step_hi;
        case (op_q)
            3'd0:         final_data = prod_fix[31:0];
            3'd4, 3'd5:   final_data = quot_fix;
            3'd6, 3'd7:   final_data = rem_fix;
            default:      final_data = prod_fix[63:32];
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        m_d         = m_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_wb_en_d = rsp_wb_en_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_op_ok) begin
                    op_d        = req_idx;
                    neg_a_d     = req_neg_a;
                    neg_b_d     = req_neg_b;
                    m_d         = req_idx[2] ? req_mag_b : req_mag_a;
                    hi_d        = 32'd0;
                    lo_d        = req_idx[2] ? req_mag_a : req_mag_b;
                    cnt_d       = 5'd0;
                    rsp_rd_d    = req_rd;
                    rsp_pc_d    = req_pc;
                    rsp_wb_en_d = (req_rd != 5'd0);
                    if (req_early) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = req_early_data;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                // Steps run at counter 0..31; the 32nd step lands in DONE.
                if (cnt_q == 5'd31) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = final_data;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Flush wins over any accept, step or pending result.
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = 5'd0;
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            op_q        <= 3'd0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            m_q         <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_rd_q    <= 5'd0;
            rsp_pc_q    <= 32'd0;
            rsp_wb_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            m_q         <= m_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_wb_en_q <= rsp_wb_en_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !rst && ((state_q != IDLE) ||
                                (req_valid && req_op_ok && (state_q == IDLE)));
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_pc    = rsp_pc_q;
    assign rsp_wb_en = rsp_wb_en_q;

endmodule

// File: tb/tb_rv32_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_muldiv_ctrl
//
// Scoreboard bench: the driver pushes hand-computed expected responses into
// a queue when it issues a request; a monitor on the falling edge pops and
// compares on every response handshake, including the accept-to-valid
// latency. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rv32_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_alu_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;
    logic        flush;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_pc;
    logic        rsp_wb_en;

    always #5 clk = ~clk;

    rv32_muldiv_ctrl #(.EARLY_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_alu_op (req_alu_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .req_pc     (req_pc),
        .flush      (flush),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_pc     (rsp_pc),
        .rsp_wb_en  (rsp_wb_en)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          first_lat = 0;
    bit          prev_v = 1'b0;
    bit          seen_valid = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency measured when rsp_valid first rises, fields compared
    // when the handshake is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) seen_valid = 1'b1;
            if (rsp_valid && !prev_v) first_lat = cyc - accept_cyc + 1;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got data %h want no response", rsp_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("rsp pc=%h rd=%0d wb=%0d data=%h lat=%0d (want %h lat %0d)",
                             rsp_pc, rsp_rd, rsp_wb_en, rsp_data, first_lat, mon_e.data, mon_e.lat);
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, mon_e.rd});
                    chk("rsp_pc", rsp_pc, mon_e.pc);
                    chk("rsp_wb_en", {31'd0, rsp_wb_en}, {31'd0, (mon_e.rd != 5'd0)});
                    chk("latency", first_lat, mon_e.lat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; optionally register its expectation.
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_data,
                        input int lat, input bit push);
        exp_t e;
        if (push) chk("req_ready_before_send", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_alu_op = op;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        req_pc     = pc_ctr;
        if (push) begin
            e.data = exp_data; e.rd = rd; e.pc = pc_ctr; e.lat = lat;
            sb_q.push_back(e);
        end
        pc_ctr = pc_ctr + 32'd4;
        tick();
        accept_cyc = cyc;
        req_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !req_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input int lat);
        send(op, a, b, rd, exp_data, lat, 1'b1);
        drain();
    endtask

    task automatic quiet_window(input string name, input int n);
        seen_valid = 1'b0;
        repeat (n) tick();
        chk(name, {31'd0, seen_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_alu_op = 6'd0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; req_pc = '0; flush = 1'b0; rsp_ready = 1'b1;

        // Reset state, with a valid MUL request held on the inputs.
        tick();
        req_valid = 1'b1; req_alu_op = 6'd38;
        tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        chk("rst_rsp_wb_en", {31'd0, rsp_wb_en}, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        tick();
        chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Multiply.
        run(6'd38, 32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
        run(6'd41, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
        run(6'd39, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33);
        run(6'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
        run(6'd39, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33);
        // Divide.
        run(6'd42, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD, 33);
        run(6'd44, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF, 33);
        run(6'd43, 32'd7,         32'd2,         5'd8, 32'd3,         33);
        run(6'd42, 32'd7,         32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 33);
        run(6'd44, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1,        33);
        run(6'd43, 32'hFFFF_FFFF, 32'h10,        5'd11, 32'h0FFF_FFFF, 33);
        run(6'd45, 32'hFFFF_FFFF, 32'h10,        5'd12, 32'hF,         33);
        run(6'd43, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         33);
        // Early-out divide-by-zero and signed overflow.
        run(6'd42, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
        run(6'd44, 32'd5,         32'd0,         5'd15, 32'd5,         1);
        run(6'd43, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1);
        run(6'd45, 32'd5,         32'd0,         5'd17, 32'd5,         1);
        run(6'd42, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
        run(6'd44, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);
        // rd = 0 still returns the result, with write-back disabled.
        run(6'd38, 32'd6,         32'd7,         5'd0,  32'd42,        33);

        // Non-M opcodes are ignored.
        req_valid = 1'b1; req_alu_op = 6'd37; req_rs1 = 32'd1; req_rs2 = 32'd1;
        chk("bad_op37_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("bad_op37_ready", {31'd0, req_ready}, 32'd1);
        req_alu_op = 6'd46;
        chk("bad_op46_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("bad_op46_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        quiet_window("bad_op_no_rsp", 40);

        // Flush beats a simultaneous accept.
        req_valid = 1'b1; req_alu_op = 6'd38; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept_ready", {31'd0, req_ready}, 32'd1);
        quiet_window("flush_vs_accept_no_rsp", 40);

        // Response back-pressure: outputs hold, a new request is ignored.
        rsp_ready = 1'b0;
        send(6'd41, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 33, 1'b1);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin tick(); n++; end
            chk("stall_valid_timeout", n < 100 ? 32'd1 : 32'd0, 32'd1);
        end
        repeat (5) begin
            req_valid = 1'b1; req_alu_op = 6'd43; req_rs1 = 32'd1; req_rs2 = 32'd1;
            tick();
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_rsp_data", rsp_data, 32'hFFFF_FFFE);
            chk("stall_rsp_rd", {27'd0, rsp_rd}, 32'd9);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        quiet_window("stall_no_extra_rsp", 40);

        // Flush at counter 10 drops the operation.
        send(6'd38, 32'd100, 32'd100, 5'd3, 32'd0, 0, 1'b0);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        quiet_window("flush_no_rsp", 40);
        run(6'd38, 32'd3, 32'd4, 5'd0, 32'd12, 33);

        // Reset mid-CALC produces no response.
        send(6'd42, 32'd100, 32'd7, 5'd4, 32'd0, 0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        quiet_window("rst_mid_calc_no_rsp", 40);
        chk("rst_mid_calc_ready", {31'd0, req_ready}, 32'd1);
        run(6'd43, 32'd100, 32'd7, 5'd4, 32'd14, 33);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
